// File: rtl/rose_ack_if.sv
// Request/acknowledge link between a bench-side initiator and the rose_ack responder.
// The initiator drives req/req_id; the responder returns readiness, the ack/nack pulses and the drop count.
interface rose_ack_if #(
  parameter int ID_W  = 4,
  parameter int CNT_W = 8
);
  logic             req;
  logic [ID_W-1:0]  req_id;
  logic             req_ready;
  logic             ack;
  logic [ID_W-1:0]  rsp_id;
  logic             nack;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output req, req_id,
    input  req_ready, ack, rsp_id, nack, drop_cnt
  );

  modport slave (
    input  req, req_id,
    output req_ready, ack, rsp_id, nack, drop_cnt
  );
endinterface

// File: rtl/rose_ack_responder.sv
// Responder that acks every accepted request exactly LATENCY edges later as a clean rising pulse.
// A request arriving one edge after an accept is rejected, so ack is always low before each rise.
module rose_ack_responder #(
  parameter int LATENCY = 2,
  parameter int ID_W    = 4,
  parameter int CNT_W   = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  rose_ack_if.slave bus
);

  logic [LATENCY-1:0] vld_p;
  logic [ID_W-1:0]    id_p [LATENCY];
  logic               nack_q;
  logic [CNT_W-1:0]   drop_cnt_q;
  logic               accept;
  logic               reject;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  // A fresh accept in stage 0 blocks the next edge; that gap is what keeps every ack a true rise.
  assign accept = bus.req & ~vld_p[0];
  assign reject = bus.req &  vld_p[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p      <= '0;
      for (int k = 0; k < LATENCY; k++) id_p[k] <= '0;
      nack_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      // stage 0: capture the accept decision and its ID
      vld_p[0] <= accept;
      id_p[0]  <= bus.req_id;
      // stages 1..LATENCY-1: plain shift toward the ack output
      for (int k = 1; k < LATENCY; k++) begin
        vld_p[k] <= vld_p[k-1];
        id_p[k]  <= id_p[k-1];
      end
      nack_q <= reject;
      if (reject) drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  assign bus.req_ready = ~vld_p[0];
  assign bus.ack       = vld_p[LATENCY-1];
  assign bus.rsp_id    = vld_p[LATENCY-1] ? id_p[LATENCY-1] : '0;
  assign bus.nack      = nack_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rose_ack_responder.sv
// Bench for rose_ack_responder: three builds (L=2/CNT 8, L=1/CNT 2, L=4/CNT 8) share one stimulus
// stream and are checked against an accept-history model of the request/ack rules.
module tb_rose_ack_responder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [3:0] req_id = 4'd0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rose_ack_if #(.ID_W(4), .CNT_W(8)) ifa ();
  rose_ack_if #(.ID_W(4), .CNT_W(2)) ifb ();
  rose_ack_if #(.ID_W(4), .CNT_W(8)) ifc ();

  assign ifa.req = req;  assign ifa.req_id = req_id;
  assign ifb.req = req;  assign ifb.req_id = req_id;
  assign ifc.req = req;  assign ifc.req_id = req_id;

  rose_ack_responder #(.LATENCY(2), .ID_W(4), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  rose_ack_responder #(.LATENCY(1), .ID_W(4), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  rose_ack_responder #(.LATENCY(4), .ID_W(4), .CNT_W(8)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  // Observed outputs packed as {req_ready, ack, nack, rsp_id, drop_cnt(8)}
  logic [14:0] obs [3];
  always_comb begin
    obs[0] = {ifa.req_ready, ifa.ack, ifa.nack, ifa.rsp_id, ifa.drop_cnt};
    obs[1] = {ifb.req_ready, ifb.ack, ifb.nack, ifb.rsp_id, 6'd0, ifb.drop_cnt};
    obs[2] = {ifc.req_ready, ifc.ack, ifc.nack, ifc.rsp_id, ifc.drop_cnt};
  end

  // Reference model: per build, which edges accepted (and with which ID), plus nack/drop state.
  int          lat  [3] = '{2, 1, 4};
  int          cmax [3] = '{255, 3, 255};
  int          edge_n = 0;
  bit          acc_ring [3][16];
  logic [3:0]  id_ring  [3][16];
  bit          last_acc [3];
  bit          nack_m   [3];
  logic [7:0]  drop_m   [3];

  function automatic void model_update(input bit r, input logic [3:0] id, input bit rn);
    for (int d = 0; d < 3; d++) begin
      if (!rn) begin
        for (int j = 0; j < 16; j++) acc_ring[d][j] = 1'b0;
        last_acc[d] = 1'b0;
        nack_m[d]   = 1'b0;
        drop_m[d]   = 8'd0;
      end else begin
        // No two accepts on consecutive edges; anything in between is dropped.
        acc_ring[d][edge_n % 16] = r && !last_acc[d];
        id_ring[d][edge_n % 16]  = id;
        nack_m[d] = r && last_acc[d];
        if (r && last_acc[d] && int'(drop_m[d]) < cmax[d]) drop_m[d] = drop_m[d] + 8'd1;
        last_acc[d] = r && !last_acc[d];
      end
    end
    edge_n++;
  endfunction

  // Expected outputs after the most recent edge: ack is visible after the edge LATENCY-1 past the accept.
  function automatic logic [14:0] exp_pack(input int d);
    int         idx;
    bit         a;
    logic [3:0] rid;
    idx = (edge_n + 16 - lat[d]) % 16;
    a   = acc_ring[d][idx];
    rid = a ? id_ring[d][idx] : 4'd0;
    return {!last_acc[d], a, nack_m[d], rid, drop_m[d]};
  endfunction

  task automatic drive_edge(input bit r, input logic [3:0] id, input bit rn);
    req = r; req_id = id; rst_n = rn;
    @(posedge clk);
    model_update(r, id, rn);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_edge(1'b1, 4'd9, 1'b0);
    drive_edge(1'b0, 4'd0, 1'b0);
    for (int d = 0; d < 3; d++) begin
      tests_run++;
      if (obs[d] !== 15'h4000) begin
        tests_failed++; $display("FAIL reset dut%0d got %h want %h", d, obs[d], 15'h4000);
      end
    end
  endtask

  task automatic test_single();
    drive_edge(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive_edge(i == 0, 4'd5, 1'b1);
      for (int d = 0; d < 3; d++) begin
        tests_run++;
        if (obs[d] !== exp_pack(d)) begin
          tests_failed++; $display("FAIL single dut%0d i=%0d got %h want %h", d, i, obs[d], exp_pack(d));
        end
      end
      tests_run++;
      if (ifa.ack !== 1'(i == 1) || ifa.rsp_id !== ((i == 1) ? 4'd5 : 4'd0) || ifa.nack !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_a i=%0d got ack=%b id=%0d nack=%b want ack=%b id=%0d nack=0",
                 i, ifa.ack, ifa.rsp_id, ifa.nack, (i == 1), (i == 1) ? 5 : 0);
      end
    end
    tests_run++;
    if (ifa.drop_cnt !== 8'd0) begin
      tests_failed++; $display("FAIL single_drop got %0d want 0", ifa.drop_cnt);
    end
  endtask

  task automatic test_held();
    logic [3:0] want_id;
    drive_edge(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive_edge(i < 4, 4'(i + 1), 1'b1);
      for (int d = 0; d < 3; d++) begin
        tests_run++;
        if (obs[d] !== exp_pack(d)) begin
          tests_failed++; $display("FAIL held dut%0d i=%0d got %h want %h", d, i, obs[d], exp_pack(d));
        end
      end
      want_id = (i == 1) ? 4'd1 : (i == 3) ? 4'd3 : 4'd0;
      tests_run++;
      if (ifa.ack !== 1'(i == 1 || i == 3) || ifa.rsp_id !== want_id || ifa.nack !== 1'(i == 1 || i == 3)) begin
        tests_failed++;
        $display("FAIL held_a i=%0d got ack=%b id=%0d nack=%b want id=%0d", i, ifa.ack, ifa.rsp_id, ifa.nack, want_id);
      end
    end
    tests_run++;
    if (ifa.drop_cnt !== 8'd2) begin
      tests_failed++; $display("FAIL held_drop got %0d want 2", ifa.drop_cnt);
    end
  endtask

  task automatic test_reset_midflight();
    drive_edge(1'b0, 4'd0, 1'b0);
    drive_edge(1'b1, 4'd7, 1'b1);
    drive_edge(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      for (int d = 0; d < 3; d++) begin
        tests_run++;
        if (obs[d] !== 15'h4000) begin
          tests_failed++; $display("FAIL midreset dut%0d i=%0d got %h want %h", d, i, obs[d], 15'h4000);
        end
      end
      drive_edge(1'b0, 4'd0, 1'b1);
    end
  endtask

  task automatic test_saturate();
    int acks_b = 0;
    int want;
    drive_edge(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive_edge(i < 12, 4'(i), 1'b1);
      if (ifb.ack === 1'b1) acks_b++;
      for (int d = 0; d < 3; d++) begin
        tests_run++;
        if (obs[d] !== exp_pack(d)) begin
          tests_failed++; $display("FAIL sat dut%0d i=%0d got %h want %h", d, i, obs[d], exp_pack(d));
        end
      end
      want = ((i + 1) / 2 > 3) ? 3 : (i + 1) / 2;
      tests_run++;
      if (int'(ifb.drop_cnt) != want) begin
        tests_failed++; $display("FAIL sat_drop i=%0d got %0d want %0d", i, ifb.drop_cnt, want);
      end
    end
    tests_run++;
    if (acks_b != 6) begin
      tests_failed++; $display("FAIL sat_acks got %0d want 6", acks_b);
    end
  endtask

  task automatic test_latency();
    logic [7:0] mask_b = '0;
    logic [7:0] mask_c = '0;
    drive_edge(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_edge(i == 0 || i == 2, 4'(i + 8), 1'b1);
      mask_b[i] = ifb.ack;
      mask_c[i] = ifc.ack;
      if (i == 3) begin
        tests_run++;
        if (ifc.rsp_id !== 4'd8) begin
          tests_failed++; $display("FAIL lat4_id got %0d want 8", ifc.rsp_id);
        end
      end
    end
    tests_run++;
    if (mask_b !== 8'b0000_0101) begin
      tests_failed++; $display("FAIL lat1_mask got %b want 00000101", mask_b);
    end
    tests_run++;
    if (mask_c !== 8'b0010_1000) begin
      tests_failed++; $display("FAIL lat4_mask got %b want 00101000", mask_c);
    end
  endtask

  task automatic test_random();
    logic [14:0] e;
    bit          prev_ack [3] = '{1'b0, 1'b0, 1'b0};
    bit          r;
    int          reqs = 0;
    int          acks = 0;
    drive_edge(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 10000; i++) begin
      drive_edge(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 499) != 0);
      for (int d = 0; d < 3; d++) begin
        e = exp_pack(d);
        tests_run++;
        if (obs[d] !== e) begin
          tests_failed++; $display("FAIL rand dut%0d i=%0d got %h want %h", d, i, obs[d], e);
        end
        if (e[13] && rst_n) begin
          tests_run++;
          if (!(obs[d][13] === 1'b1 && !prev_ack[d])) begin
            tests_failed++; $display("FAIL rose dut%0d i=%0d got ack=%b prev=%b want rise", d, i, obs[d][13], prev_ack[d]);
          end
        end
        prev_ack[d] = (obs[d][13] === 1'b1);
      end
    end
    // Every request is either acked or counted as dropped while the counter is unsaturated.
    drive_edge(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 206; i++) begin
      r = (i < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (r) reqs++;
      drive_edge(r, 4'($urandom_range(0, 15)), 1'b1);
      if (ifa.ack === 1'b1) acks++;
    end
    tests_run++;
    if (acks + int'(ifa.drop_cnt) != reqs) begin
      tests_failed++; $display("FAIL conserve got acks=%0d drops=%0d want total %0d", acks, ifa.drop_cnt, reqs);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_held();
    test_reset_midflight();
    test_saturate();
    test_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/rose_ack_responder.md
Name: rose_ack_responder

Overview:
- Request/acknowledge responder for the `req |-> ##LATENCY $rose(ack)` handshake used by the team's concurrent-assertion benches.
- Every accepted request produces a single-cycle ack pulse exactly LATENCY cycles later, with the request ID returned alongside the pulse.
- Requests that would break the `$rose` guarantee are rejected, flagged and counted.
- Sits on the responder side of the req/ack link, opposite the bench-side initiator and checker.

Parameters:
- LATENCY, 2, edges from the edge where req is sampled to the edge where ack is sampled high; legal range 1..8.
- ID_W, 4, width of the request/response ID.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset.
- req  input  1  request, sampled at posedge.
- req_id  input  ID_W  ID sampled with req.
- req_ready  output  1  high when a req sampled at the next posedge will be accepted.
- ack  output  1  registered one-cycle acknowledge pulse.
- rsp_id  output  ID_W  ID of the acknowledged request; valid only while ack=1, 0 otherwise.
- nack  output  1  registered one-cycle pulse marking a rejected request.
- drop_cnt  output  CNT_W  saturating count of rejected requests.

Behaviour:
- Reset is synchronous: rst_n sampled low at a posedge sets the following, regardless of in-flight requests; pending acks are discarded:
  - pipeline valid bits = 0, pipeline IDs = 0
  - ack = 0, rsp_id = 0, nack = 0, drop_cnt = 0, req_ready = 1
- The req sampled on the reset edge is ignored.
- Acceptance:
  - accept = req & req_ready at posedge N.
  - req_ready = ~v[0], where v[0] is the valid bit of pipeline stage 0.
  - So no two accepts occur on consecutive edges; a minimum spacing of 2 cycles guarantees ack is low on the edge before each rising sample.
- Pipeline:
  - LATENCY stages of {v, id}. Stage 0 loads {accept, req_id} at edge N; stage k loads stage k-1 on each edge.
  - ack = v[LATENCY-1]; rsp_id = v[LATENCY-1] ? id[LATENCY-1] : 0.
  - Timing: req sampled at edge N → ack sampled 0 at edge N+LATENCY-1 and 1 at edge N+LATENCY; ack is 0 again at edge N+LATENCY+1 unless a new accept occurred at edge N+2 with LATENCY aligned.
  - For LATENCY=1: ack rises after edge N and is sampled 1 at edge N+1.
- Rejection:
  - req & ~req_ready at edge N → nack=1 for the cycle after edge N.
  - drop_cnt increments by 1, saturating at 2^CNT_W-1, where it holds.
  - A rejected request never produces ack.
- Continuous req held high: accepts on alternate edges (accept, reject, accept, ...). ack toggles 1,0,1,... with period 2 after the initial latency; nack pulses interleave.
- No other state machine. The block is a valid/ID shift pipeline plus a saturating counter.
- Guaranteed property: for every accepted request at edge N, `$rose(ack)` holds at edge N+LATENCY.

Test Plan:
- Reset, then req=1, req_id=5 for one cycle at edge 3 (LATENCY=2) → ack sampled 0 at edge 4, 1 at edge 5, 0 at edge 6; rsp_id=5 at edge 5; nack never asserted; drop_cnt=0.
- req held 1 for 4 edges (3..6) with IDs 1,2,3,4 → accepts IDs 1 and 3 at edges 3 and 5; acks sampled at edges 5 and 7 with rsp_id 1 and 3; nack after edges 4 and 6; drop_cnt=2.
- req at edge 3, then rst_n=0 sampled at edge 4 → no ack at edge 5; all outputs 0, req_ready=1 at edges 5 and 6.
- CNT_W=2, req held high for 12 edges → drop_cnt reaches 3 after the 3rd rejection and stays 3; 6 acks observed.
- LATENCY=1 and LATENCY=4 builds, req at edges 3 and 5 → acks at edges 4 and 6, and at edges 7 and 9 respectively; bound `$rose` assertion passes on every accept.
- Random req/req_id for 10k cycles with bound `req && req_ready |-> ##LATENCY $rose(ack)` → zero assertion failures; accepts + drop_cnt equals total req count while below saturation.
